// File: rtl/div_pkg.sv
// Shared constants and arithmetic helpers for the serial divisibility checker.
package div_pkg;

    localparam int unsigned DIVISOR_MAX = 255;
    localparam int unsigned NUM_CH_MAX  = 32;

    // Width needed to hold a remainder in 0..divisor-1.
    function automatic int unsigned rem_width(input int unsigned divisor);
        return (divisor <= 2) ? 1 : $clog2(divisor);
    endfunction

    // One MSB-first step: (2*base + bit) mod divisor, valid because base < divisor.
    function automatic logic [7:0] mod_step(input logic [7:0] base,
                                            input logic       bit_in,
                                            input logic [7:0] divisor);
        logic [8:0] t;
        t = {base, bit_in};
        if (t >= {1'b0, divisor}) begin
            t = t - {1'b0, divisor};
        end
        return t[7:0];
    endfunction

endpackage

// File: rtl/div_chk_lane.sv
// One channel: running remainder, divisible flag, result strobe and, with
// DIV_CHK_LEN_CNT_EN defined, a saturating bit counter.
module div_chk_lane
    import div_pkg::*;
#(
    parameter int unsigned DIVISOR = 3,
`ifdef DIV_CHK_LEN_CNT_EN
    parameter int unsigned CNT_W   = 16,
`endif
    localparam int unsigned RW     = rem_width(DIVISOR)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             vld,
    input  logic             sof,
    output logic             divisible,
    output logic             result_vld,
`ifdef DIV_CHK_LEN_CNT_EN
    output logic [CNT_W-1:0] bit_cnt,
`endif
    output logic [RW-1:0]    remainder
);

    logic [RW-1:0] base;
    logic [RW-1:0] rem_next;

    always_comb begin
        base     = sof ? '0 : remainder;
        rem_next = RW'(mod_step(8'(base), bit_in, 8'(DIVISOR)));
    end

    // The remainder output doubles as the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remainder  <= '0;
            divisible  <= 1'b1;
            result_vld <= 1'b0;
        end else begin
            result_vld <= vld;
            if (vld) begin
                remainder <= rem_next;
                divisible <= (rem_next == '0);
            end
        end
    end

`ifdef DIV_CHK_LEN_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
        end else if (vld) begin
            if (sof) begin
                bit_cnt <= CNT_W'(1);
            end else if (bit_cnt != '1) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: rtl/div_n_chk_mc.sv
// Multi-channel MSB-first divisibility checker; one lane per channel.
// Define DIV_CHK_LEN_CNT_EN to add the per-channel bit_cnt output.
module div_n_chk_mc
    import div_pkg::*;
#(
    parameter int unsigned DIVISOR = 3,
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned RW     = rem_width(DIVISOR)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       bitstream,
    input  logic [NUM_CH-1:0]       bitstream_vld,
    input  logic [NUM_CH-1:0]       bitstream_sof,
    output logic [NUM_CH-1:0]       divisible,
    output logic [NUM_CH-1:0]       result_vld,
`ifdef DIV_CHK_LEN_CNT_EN
    output logic [NUM_CH*CNT_W-1:0] bit_cnt,
`endif
    output logic [NUM_CH*RW-1:0]    remainder
);

    if (DIVISOR < 2 || DIVISOR > DIVISOR_MAX) begin : g_bad_divisor
        $fatal(1, "div_n_chk_mc: DIVISOR %0d outside 2..%0d", DIVISOR, DIVISOR_MAX);
    end
    if (NUM_CH < 1 || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
        $fatal(1, "div_n_chk_mc: NUM_CH %0d outside 1..%0d", NUM_CH, NUM_CH_MAX);
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $fatal(1, "div_n_chk_mc: CNT_W must be at least 1");
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        div_chk_lane #(
`ifdef DIV_CHK_LEN_CNT_EN
            .CNT_W     (CNT_W),
`endif
            .DIVISOR   (DIVISOR)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .bit_in    (bitstream[c]),
            .vld       (bitstream_vld[c]),
            .sof       (bitstream_sof[c]),
            .divisible (divisible[c]),
            .result_vld(result_vld[c]),
`ifdef DIV_CHK_LEN_CNT_EN
            .bit_cnt   (bit_cnt[c*CNT_W +: CNT_W]),
`endif
            .remainder (remainder[c*RW +: RW])
        );
    end

endmodule

// File: tb/tb_div_n_chk_mc.sv
// Randomized and directed checks of div_n_chk_mc for divisors 3, 7 and 5 driven
// in parallel, against an arithmetic reference model.
module tb_div_n_chk_mc;

    localparam int NCH = 4;
    localparam int CW  = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic [NCH-1:0] bs, vld, sof;
    logic [NCH-1:0] div3, rv3, div7, rv7, div5, rv5;
    logic [7:0]  rem3;
    logic [11:0] rem7, rem5;
`ifdef DIV_CHK_LEN_CNT_EN
    logic [NCH*CW-1:0] bc3, bc7, bc5;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit run = 1'b0;

    int divs [3] = '{3, 7, 5};
    int m_r   [3][NCH];
    int m_vld [3][NCH];
    int m_cnt [3][NCH];

    always #5 clk = ~clk;

    div_n_chk_mc #(.DIVISOR(3), .NUM_CH(NCH), .CNT_W(CW)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bitstream(bs), .bitstream_vld(vld), .bitstream_sof(sof),
        .divisible(div3), .result_vld(rv3),
`ifdef DIV_CHK_LEN_CNT_EN
        .bit_cnt(bc3),
`endif
        .remainder(rem3));

    div_n_chk_mc #(.DIVISOR(7), .NUM_CH(NCH), .CNT_W(CW)) u_dut7 (
        .clk(clk), .rst_n(rst_n), .bitstream(bs), .bitstream_vld(vld), .bitstream_sof(sof),
        .divisible(div7), .result_vld(rv7),
`ifdef DIV_CHK_LEN_CNT_EN
        .bit_cnt(bc7),
`endif
        .remainder(rem7));

    div_n_chk_mc #(.DIVISOR(5), .NUM_CH(NCH), .CNT_W(CW)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .bitstream(bs), .bitstream_vld(vld), .bitstream_sof(sof),
        .divisible(div5), .result_vld(rv5),
`ifdef DIV_CHK_LEN_CNT_EN
        .bit_cnt(bc5),
`endif
        .remainder(rem5));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 60) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the number seen so far, reduced mod d with plain arithmetic.
    function automatic int next_r(input int r, input logic s, input logic b, input int d);
        return ((s ? 0 : r) * 2 + int'(b)) % d;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++)
                for (int c = 0; c < NCH; c++) begin
                    m_r[k][c]   <= 0;
                    m_vld[k][c] <= 0;
                    m_cnt[k][c] <= 0;
                end
        end else begin
            for (int k = 0; k < 3; k++)
                for (int c = 0; c < NCH; c++) begin
                    m_vld[k][c] <= int'(vld[c]);
                    if (vld[c]) begin
                        m_r[k][c]   <= next_r(m_r[k][c], sof[c], bs[c], divs[k]);
                        m_cnt[k][c] <= sof[c] ? 1 : ((m_cnt[k][c] < (1 << CW) - 1) ?
                                                     m_cnt[k][c] + 1 : m_cnt[k][c]);
                    end
                end
        end
    end

    function automatic logic [31:0] act_rem(input int k, input int c);
        case (k)
            0:       return 32'(rem3[c*2 +: 2]);
            1:       return 32'(rem7[c*3 +: 3]);
            default: return 32'(rem5[c*3 +: 3]);
        endcase
    endfunction

    function automatic logic [31:0] act_div(input int k, input int c);
        case (k)
            0:       return 32'(div3[c]);
            1:       return 32'(div7[c]);
            default: return 32'(div5[c]);
        endcase
    endfunction

    function automatic logic [31:0] act_vld(input int k, input int c);
        case (k)
            0:       return 32'(rv3[c]);
            1:       return 32'(rv7[c]);
            default: return 32'(rv5[c]);
        endcase
    endfunction

`ifdef DIV_CHK_LEN_CNT_EN
    function automatic logic [31:0] act_cnt(input int k, input int c);
        case (k)
            0:       return 32'(bc3[c*CW +: CW]);
            1:       return 32'(bc7[c*CW +: CW]);
            default: return 32'(bc5[c*CW +: CW]);
        endcase
    endfunction
`endif

    always @(negedge clk) begin
        if (run) begin
            for (int k = 0; k < 3; k++)
                for (int c = 0; c < NCH; c++) begin
                    check($sformatf("model D%0d ch%0d remainder", divs[k], c),
                          act_rem(k, c), 32'(m_r[k][c]));
                    check($sformatf("model D%0d ch%0d divisible", divs[k], c),
                          act_div(k, c), 32'(m_r[k][c] == 0));
                    check($sformatf("model D%0d ch%0d result_vld", divs[k], c),
                          act_vld(k, c), 32'(m_vld[k][c]));
`ifdef DIV_CHK_LEN_CNT_EN
                    check($sformatf("model D%0d ch%0d bit_cnt", divs[k], c),
                          act_cnt(k, c), 32'(m_cnt[k][c]));
`endif
                end
        end
    end

    task automatic cyc(input logic [NCH-1:0] v, input logic [NCH-1:0] s, input logic [NCH-1:0] b);
        vld = v;
        sof = s;
        bs  = b;
        @(negedge clk);
    endtask

    // Pulse reset between a falling and the next rising edge; inputs idle.
    task automatic pulse_reset(input string tag);
        vld = '0;
        sof = '0;
        bs  = '0;
        #1 rst_n = 1'b0;
        #1;
        check({tag, " rem3 in reset"}, 32'(rem3), 32'd0);
        check({tag, " rem7 in reset"}, 32'(rem7), 32'd0);
        check({tag, " div7 in reset"}, 32'(div7), 32'hF);
        check({tag, " rv7 in reset"},  32'(rv7),  32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    int exp7 [6] = '{1, 2, 5, 3, 0, 0};
    logic [5:0] bits42 = 6'b101010;

    initial begin
        rst_n = 1'b0;
        vld = '0;
        sof = '0;
        bs  = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset rem5", 32'(rem5), 32'd0);
        check("reset div5", 32'(div5), 32'hF);
        check("reset rv5",  32'(rv5),  32'd0);
        rst_n = 1'b1;
        run   = 1'b1;
        @(negedge clk);

        // Divisor 3, channel 0: sof+1, 1, 0.
        cyc(4'h1, 4'h1, 4'h1);
        check("d3 step1 rem", 32'(rem3[1:0]), 32'd1);
        check("d3 step1 div", 32'(div3[0]), 32'd0);
        check("d3 step1 vld", 32'(rv3[0]), 32'd1);
        cyc(4'h1, 4'h0, 4'h1);
        check("d3 step2 rem", 32'(rem3[1:0]), 32'd0);
        check("d3 step2 div", 32'(div3[0]), 32'd1);
        cyc(4'h1, 4'h0, 4'h0);
        check("d3 step3 rem", 32'(rem3[1:0]), 32'd0);
        check("d3 step3 vld", 32'(rv3[0]), 32'd1);
        cyc(4'h0, 4'h0, 4'h0);
        check("d3 idle vld", 32'(rv3[0]), 32'd0);

        // Divisor 7: value 42 MSB-first.
        for (int i = 0; i < 6; i++) begin
            cyc(4'h1, (i == 0) ? 4'h1 : 4'h0, {3'b0, bits42[5-i]});
            check($sformatf("d7 42 rem %0d", i), 32'(rem7[2:0]), 32'(exp7[i]));
            check($sformatf("d7 42 div %0d", i), 32'(div7[0]), 32'(i >= 4));
        end

        // Mid-stream sof restarts the number.
        pulse_reset("pre-sof");
        cyc(4'h1, 4'h0, 4'h1);
        cyc(4'h1, 4'h0, 4'h1);
        check("d7 implicit sof rem", 32'(rem7[2:0]), 32'd3);
        cyc(4'h1, 4'h1, 4'h1);
        check("d7 mid sof rem", 32'(rem7[2:0]), 32'd1);
        cyc(4'h0, 4'h1, 4'h1);
        check("d7 sof no vld rem", 32'(rem7[2:0]), 32'd1);
        check("d7 sof no vld rv", 32'(rv7[0]), 32'd0);

        // Reset mid-number, then a fresh bit 1.
        cyc(4'h1, 4'h0, 4'h1);
        pulse_reset("mid-number");
        cyc(4'h1, 4'h0, 4'h1);
        check("d7 after reset rem", 32'(rem7[2:0]), 32'd1);

        // Divisor 5, all channels together with a gap.
        cyc(4'hF, 4'hF, 4'b1101);
        cyc(4'hF, 4'h0, 4'b0110);
        cyc(4'h0, 4'h0, 4'h0);
        check("d5 gap rv", 32'(rv5), 32'd0);
        check("d5 gap rem ch0", 32'(rem5[2:0]), 32'd2);
        cyc(4'hF, 4'h0, 4'hF);
        check("d5 all rem", 32'(rem5), 32'({3'd0, 3'd2, 3'd3, 3'd0}));
        check("d5 all div", 32'(div5), 32'(4'b1001));

`ifdef DIV_CHK_LEN_CNT_EN
        pulse_reset("cnt");
        for (int i = 0; i < 9; i++) begin
            cyc(4'h1, 4'h0, 4'(i & 1));
            check($sformatf("bit_cnt step %0d", i), 32'(bc3[CW-1:0]), 32'((i < 7) ? i + 1 : 7));
        end
        cyc(4'h1, 4'h1, 4'h0);
        check("bit_cnt after sof", 32'(bc3[CW-1:0]), 32'd1);
`endif

        // Randomized traffic on all channels.
        for (int i = 0; i < 400; i++) begin
            cyc(4'($urandom), 4'($urandom & $urandom), 4'($urandom));
        end
        cyc(4'h0, 4'h0, 4'h0);

        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
